usrt_receiver: RTL

USRT_RECEIVER -- requirements
Module: usrt_receiver

---
 rtl/usrt_pkg.sv | 23 ++
 rtl/usrt_rx_fifo.sv | 54 +++++
 rtl/usrt_receiver.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: receiver FSM states, default bit timing and frame geometry.
package usrt_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 80;
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned START_BITS      = 1;
  localparam int unsigned STOP_BITS       = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Total bit periods in one frame, including the optional parity bit.
  function automatic int unsigned frame_bits(bit parity_en);
    return START_BITS + DATA_BITS + (parity_en ? 1 : 0) + STOP_BITS;
  endfunction

endpackage

// File: rtl/usrt_rx_fifo.sv
// Receive FIFO: byte-wide, power-of-two depth, occupancy counter one bit wider than the pointers.
module usrt_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       pClk,
  input  logic       pReset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge pClk) begin
    if (pReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the counter alone defines which entries are live.
  always_ff @(posedge pClk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/usrt_receiver.sv
// USRT receiver: synchronized serial input, mid-bit sampling FSM, parity/stop checks, receive FIFO.
module usrt_receiver
  import usrt_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic       pClk,
  input  logic       pReset,
  input  logic       Tx,
  input  logic       rPop,
  input  logic       errClr,
  output logic [7:0] rData,
  output logic       rValid,
  output logic       rFull,
  output logic       parityErr,
  output logic       frameErr,
  output logic       overrun
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  rx_state_e        state_q, state_d;
  logic             tx_meta_q, txs_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bad_q, par_bad_d;
  logic             push_q, push_d;
  logic             par_evt_q, par_evt_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             frame_evt, ovr_evt, tick;
  logic             fifo_full, fifo_empty;

  assign tick = (div_q == '0);

  // NOTE: every flop is updated with <= so all registers see pre-edge values, independent of order.
  always_ff @(posedge pClk) begin
    if (pReset) begin
      tx_meta_q    <= 1'b1;
      txs_q        <= 1'b1;
      state_q      <= ST_IDLE;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      push_q       <= 1'b0;
      par_evt_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tx_meta_q    <= Tx;
      txs_q        <= tx_meta_q;
      state_q      <= state_d;
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      push_q       <= push_d;
      par_evt_q    <= par_evt_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!txs_q) state_d = ST_START;
      ST_START:  if (tick) state_d = txs_q ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && bit_cnt_q == LAST_BIT) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick) state_d = txs_q ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (txs_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: each variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push_d    = 1'b0;
    frame_evt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!txs_q) begin
          div_d     = DIV_HALF;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
        div_d = tick ? DIV_FULL : div_q - 1'b1;
        if (tick) begin
          case (state_q)
            ST_START:  bit_cnt_d = '0;
            ST_DATA: begin
              shift_d   = {txs_q, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
            ST_PARITY: par_bad_d = txs_q ^ (^shift_q);
            default: begin
              push_d    = txs_q;
              frame_evt = ~txs_q;
            end
          endcase
        end
      end
      default: ;
    endcase
    par_evt_d = push_d & par_bad_q;
  end

  // A new error event wins over a simultaneous clear.
  assign ovr_evt = push_q & fifo_full & ~rPop;

  always_comb begin
    parity_err_d = (parity_err_q & ~errClr) | par_evt_q;
    frame_err_d  = (frame_err_q  & ~errClr) | frame_evt;
    overrun_d    = (overrun_q    & ~errClr) | ovr_evt;
  end

  usrt_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .pClk   (pClk),
    .pReset (pReset),
    .push   (push_q),
    .wdata  (shift_q),
    .pop    (rPop),
    .rdata  (rData),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign rValid    = ~fifo_empty;
  assign rFull     = fifo_full;
  assign parityErr = parity_err_q;
  assign frameErr  = frame_err_q;
  assign overrun   = overrun_q;

endmodule
